ram_boot_loader: RTL and testbench

- Byte-stream boot loader for simulation and FPGA bring-up.
- Accepts a framed byte stream from a UART receiver through a valid/ready handshake.
- Packs payload bytes into 32-bit little-endian words and writes them through one write port of the dual-port program RAM, using byte-lane write enables.
- Holds the core in reset until the image is fully written. Sits directly upstream of the RAM write port, in parallel with the core's instruction/data path.

---
 rtl/ram_boot_loader_pkg.sv | 8 +
 rtl/ram_boot_loader_if.sv | 12 +
 rtl/ram_boot_loader_word_packer.sv | 54 +++++
 rtl/ram_boot_loader.sv | 83 ++++++++
 tb/tb_ram_boot_loader.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/ram_boot_loader_pkg.sv
// ram_boot_loader_pkg: shared types, constants and header check for the boot loader
package ram_boot_loader_pkg;
  typedef enum logic [2:0] {HDR_ADDR, HDR_LEN, PAYLOAD, FLUSH, DONE, ERROR} loader_state_e;
  localparam int LOADER_HDR_BYTES = 4;
  function automatic logic hdr_bad(input logic [31:0] base, input logic [31:0] len, input logic [32:0] mem);
    return (base[1:0] != 2'b00) || (({1'b0, base} + {1'b0, len}) > mem);
  endfunction
endpackage

// File: rtl/ram_boot_loader_if.sv
// ram_boot_loader_if: byte stream handshake plus RAM write port
interface ram_boot_loader_if #(parameter int AW = 16);
  logic byte_valid_i;
  logic [7:0] byte_i;
  logic byte_ready_o;
  logic en_o;
  logic [3:0] we_o;
  logic [AW-1:0] addr_o;
  logic [31:0] data_o;
  modport master (input byte_valid_i, byte_i, output byte_ready_o, en_o, we_o, addr_o, data_o);
  modport slave (output byte_valid_i, byte_i, input byte_ready_o, en_o, we_o, addr_o, data_o);
endinterface

// File: rtl/ram_boot_loader_word_packer.sv
// loader_word_packer: packs payload bytes into little-endian words and registers the write pulse
module loader_word_packer #(parameter int AW = 16) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic [AW-1:0] base,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          last,
  output logic          en,
  output logic [3:0]    we,
  output logic [AW-1:0] addr,
  output logic [31:0]   data
);
  logic [1:0] lane;
  logic [31:0] acc;
  logic [AW-1:0] waddr;
  logic [31:0] word;
  logic [3:0] fill;
  logic flush;
  // merge the incoming byte into the partial word; a word completes on lane 3 or the final byte
  always_comb begin
    word = acc | ({24'd0, din} << {lane, 3'b000});
    fill = {lane == 2'd3, lane >= 2'd2, lane >= 2'd1, 1'b1};
    flush = push && (lane == 2'd3 || last);
  end
  // partial-word accumulator, kept apart from the output register so a byte can land during a pulse
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      lane <= 2'd0;
      acc <= 32'd0;
    end else if (flush) begin
      lane <= 2'd0;
      acc <= 32'd0;
    end else if (push) begin
      lane <= lane + 2'd1;
      acc <= word;
    end
  // one-cycle write pulse; address and data hold between pulses
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      en <= 1'b0;
      we <= 4'd0;
      addr <= '0;
      data <= 32'd0;
      waddr <= '0;
    end else begin
      en <= flush;
      we <= flush ? fill : 4'd0;
      addr <= flush ? waddr : addr;
      data <= flush ? word : data;
      waddr <= load ? base : flush ? waddr + AW'(4) : waddr;
    end
endmodule

// File: rtl/ram_boot_loader.sv
// ram_boot_loader: framed byte-stream loader writing a RAM image and holding the core in reset
module ram_boot_loader
  import ram_boot_loader_pkg::*;
#(
  parameter int MEM_WIDTH = 65536,
  parameter bit HOLD_CORE = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start_i,
  ram_boot_loader_if.master bus,
  output logic busy_o,
  output logic done_o,
  output logic error_o,
  output logic core_reset_n_o
);
  localparam int AW = $clog2(MEM_WIDTH);
  loader_state_e state, state_nx;
  logic [1:0] hcnt;
  logic [31:0] base, len, len_full;
  logic [AW:0] rem;
  logic take, hdr_end, last;
  // handshake decode and the length as it stands once the current byte is included
  always_comb begin
    take = bus.byte_valid_i && bus.byte_ready_o;
    hdr_end = take && hcnt == 2'(LOADER_HDR_BYTES - 1);
    len_full = {bus.byte_i, len[31:8]};
    last = rem == (AW+1)'(1);
  end
  // state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= HDR_ADDR;
    else state <= state_nx;
  // next state: header collection, range check, payload, flush, and restart from terminal states
  always_comb begin
    state_nx = state;
    case (state)
      HDR_ADDR: state_nx = hdr_end ? HDR_LEN : HDR_ADDR;
      HDR_LEN:  state_nx = !hdr_end ? HDR_LEN : hdr_bad(base, len_full, 33'(MEM_WIDTH)) ? ERROR :
                           len_full == 32'd0 ? DONE : PAYLOAD;
      PAYLOAD:  state_nx = take && last ? FLUSH : PAYLOAD;
      FLUSH:    state_nx = DONE;
      DONE:     state_nx = start_i ? HDR_ADDR : DONE;
      ERROR:    state_nx = start_i ? HDR_ADDR : ERROR;
      default:  state_nx = HDR_ADDR;
    endcase
  end
  // header shift registers (LSB first) and remaining payload count
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      hcnt <= 2'd0;
      base <= 32'd0;
      len <= 32'd0;
      rem <= '0;
    end else begin
      if (take && state != PAYLOAD) hcnt <= hcnt + 2'd1;
      if (take && state == HDR_ADDR) base <= {bus.byte_i, base[31:8]};
      if (take && state == HDR_LEN) len <= len_full;
      if (hdr_end && state == HDR_LEN) rem <= len_full[AW:0];
      else if (take && state == PAYLOAD) rem <= rem - (AW+1)'(1);
    end
  // status outputs decoded from state
  always_comb begin
    bus.byte_ready_o = state inside {HDR_ADDR, HDR_LEN, PAYLOAD};
    busy_o = (state == HDR_ADDR && hcnt != 2'd0) || state inside {HDR_LEN, PAYLOAD, FLUSH};
    done_o = state == DONE;
    error_o = state == ERROR;
    core_reset_n_o = HOLD_CORE ? state == DONE : 1'b1;
  end
  loader_word_packer #(.AW(AW)) u_packer (
    .clk(clk),
    .reset_n(reset_n),
    .load(hdr_end && state == HDR_LEN),
    .base(base[AW-1:0]),
    .push(take && state == PAYLOAD),
    .din(bus.byte_i),
    .last(last),
    .en(bus.en_o),
    .we(bus.we_o),
    .addr(bus.addr_o),
    .data(bus.data_o)
  );
endmodule

// File: tb/tb_ram_boot_loader.sv
// tb_ram_boot_loader: directed frames with a write scoreboard checked by an independent monitor
module tb_ram_boot_loader;
  localparam int AW = 16;
  typedef struct packed {logic [AW-1:0] addr; logic [31:0] data; logic [3:0] we;} wr_t;
  logic clk = 1'b0, reset_n = 1'b0, start_i = 1'b0;
  logic busy_o, done_o, error_o, core_reset_n_o;
  int checks = 0, errors = 0;
  bit gaps = 1'b0;
  wr_t exp_q[$];
  wr_t mon_e;
  ram_boot_loader_if #(.AW(AW)) bus();
  ram_boot_loader #(.MEM_WIDTH(65536), .HOLD_CORE(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .start_i(start_i), .bus(bus),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .core_reset_n_o(core_reset_n_o)
  );
  always #5 clk = ~clk;
  // monitor: every write pulse must match the oldest expected write
  always @(negedge clk)
    if (bus.en_o === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%h data=%h we=%b", bus.addr_o, bus.data_o, bus.we_o);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.addr_o !== mon_e.addr || bus.data_o !== mon_e.data || bus.we_o !== mon_e.we) begin
          errors++;
          $display("FAIL write actual addr=%h data=%h we=%b expected addr=%h data=%h we=%b",
                   bus.addr_o, bus.data_o, bus.we_o, mon_e.addr, mon_e.data, mon_e.we);
        end
      end
    end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  task automatic expect_wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] w);
    exp_q.push_back('{addr: a, data: d, we: w});
  endtask
  task automatic send(input logic [7:0] b);
    int n = 0;
    if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    bus.byte_valid_i = 1'b1;
    bus.byte_i = b;
    while (bus.byte_ready_o !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    if (bus.byte_ready_o !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout byte=%h", b);
    end
    @(posedge clk);
    #1;
    bus.byte_valid_i = 1'b0;
    bus.byte_i = 8'hxx;
  endtask
  task automatic frame(input logic [31:0] base, input logic [31:0] len, input int n);
    for (int i = 0; i < 4; i++) send(base[8*i +: 8]);
    for (int i = 0; i < 4; i++) send(len[8*i +: 8]);
    for (int i = 0; i < n; i++) send(8'(8'h11 * (i + 1)));
  endtask
  task automatic settle_done(input string name);
    repeat (3) @(posedge clk);
    #1;
    check({name, "_done"}, done_o, 1);
    check({name, "_core_rst"}, core_reset_n_o, 1);
    check({name, "_ready"}, bus.byte_ready_o, 0);
    check({name, "_pending"}, exp_q.size(), 0);
  endtask
  task automatic restart();
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    check("restart_done", done_o, 0);
    check("restart_error", error_o, 0);
    check("restart_core_rst", core_reset_n_o, 0);
    check("restart_ready", bus.byte_ready_o, 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.byte_valid_i = 1'b0;
    bus.byte_i = 8'h00;
    #12;
    check("rst_en", bus.en_o, 0);
    check("rst_we", bus.we_o, 0);
    check("rst_addr", bus.addr_o, 0);
    check("rst_data", bus.data_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_error", error_o, 0);
    check("rst_core_rst", core_reset_n_o, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_ready", bus.byte_ready_o, 1);
    expect_wr(16'h0100, 32'h44332211, 4'b1111);
    expect_wr(16'h0104, 32'h88776655, 4'b1111);
    frame(32'h100, 32'd8, 8);
    settle_done("full");
    restart();
    expect_wr(16'h0100, 32'h44332211, 4'b1111);
    expect_wr(16'h0104, 32'h00006655, 4'b0011);
    frame(32'h100, 32'd6, 6);
    settle_done("partial");
    restart();
    frame(32'h200, 32'd0, 0);
    check("len0_done_next", done_o, 1);
    settle_done("len0");
    restart();
    expect_wr(16'hFFF8, 32'h44332211, 4'b1111);
    expect_wr(16'hFFFC, 32'h88776655, 4'b1111);
    frame(32'hFFF8, 32'd8, 8);
    settle_done("top_fit");
    restart();
    frame(32'hFFFC, 32'd8, 0);
    check("range_error", error_o, 1);
    check("range_ready", bus.byte_ready_o, 0);
    check("range_core_rst", core_reset_n_o, 0);
    repeat (3) @(posedge clk);
    #1;
    check("range_error_sticky", error_o, 1);
    restart();
    check("range_restart_busy", busy_o, 0);
    frame(32'h102, 32'd4, 0);
    check("misalign_error", error_o, 1);
    check("misalign_ready", bus.byte_ready_o, 0);
    restart();
    gaps = 1'b1;
    expect_wr(16'h0100, 32'h44332211, 4'b1111);
    expect_wr(16'h0104, 32'h88776655, 4'b1111);
    frame(32'h100, 32'd8, 8);
    gaps = 1'b0;
    settle_done("gaps");
    restart();
    expect_wr(16'h0100, 32'h44332211, 4'b1111);
    frame(32'h100, 32'd8, 7);
    check("mid_busy", busy_o, 1);
    check("mid_pending", exp_q.size(), 0);
    reset_n = 1'b0;
    #1;
    check("mid_rst_en", bus.en_o, 0);
    check("mid_rst_addr", bus.addr_o, 0);
    check("mid_rst_data", bus.data_o, 0);
    check("mid_rst_busy", busy_o, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_ready", bus.byte_ready_o, 1);
    expect_wr(16'h0100, 32'h44332211, 4'b1111);
    expect_wr(16'h0104, 32'h88776655, 4'b1111);
    frame(32'h100, 32'd8, 8);
    settle_done("after_rst");
    repeat (3) @(posedge clk);
    #1;
    check("final_pending", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
